// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory responder.
// FSM state encoding and bus widths.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/dmem_ram_array.sv
// DEPTH x 32 word store with byte-enabled write.
// Registered read port; contents are never reset.
module dmem_ram_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Byte-lane write; untouched lanes keep their data.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register: loads on a good read, zeroed on a faulted one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Req/Ack data-memory responder with WAIT_CYCLES wait states.
// Optional DMEM_ALIGN_CHECK_EN faults misaligned addresses.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              We,
  input  logic [31:0]       Addr,
  input  logic [WORD_W-1:0] WData,
  input  logic [BE_W-1:0]   BE,
  output logic              Ack,
  output logic [WORD_W-1:0] RData,
  output logic              Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmem_state_t       r_state;
  dmem_state_t       w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_ack;
  logic              r_err;

  logic              w_cap;
  logic              w_resp;
  logic              w_oor;
  logic              w_mis;
  logic              w_bad;

  assign w_cap  = (r_state == IDLE) && Req;
  assign w_resp = (r_state == RESP);
  assign w_oor  = {2'b00, r_addr[31:2]} >= 32'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = (r_addr[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^r_addr[1:0];
  assign w_mis = 1'b0;
`endif

  assign w_bad = w_oor | w_mis;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: capture, count down, respond once.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (Req) begin
          w_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_cap) begin
      r_cnt   <= CW'(WAIT_CYCLES);
      r_we    <= We;
      r_addr  <= Addr;
      r_wdata <= WData;
      r_be    <= BE;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // Response pulse and error flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_resp;
      r_err <= w_resp & w_bad;
    end
  end

  dmem_ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_we    (w_resp & r_we & ~w_bad),
    .i_re    (w_resp & ~r_we & ~w_bad),
    .i_clr   (w_resp & w_bad),
    .i_idx   (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (RData)
  );

  assign Ack = r_ack;
  assign Err = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A has 2 wait states,
// instance B has none (back-to-back case).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  logic        a_req, a_we, a_ack, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;

  logic        b_req, b_we, b_ack, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;

  int errors = 0;
  int checks = 0;

  dmem_responder #(
    .DEPTH       (256),
    .WAIT_CYCLES (2)
  ) u_dut_a (
    .Clk   (clk),
    .Rst_n (rst_n),
    .Req   (a_req),
    .We    (a_we),
    .Addr  (a_addr),
    .WData (a_wdata),
    .BE    (a_be),
    .Ack   (a_ack),
    .RData (a_rdata),
    .Err   (a_err)
  );

  dmem_responder #(
    .DEPTH       (256),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .Clk   (clk),
    .Rst_n (rst_n),
    .Req   (b_req),
    .We    (b_we),
    .Addr  (b_addr),
    .WData (b_wdata),
    .BE    (b_be),
    .Ack   (b_ack),
    .RData (b_rdata),
    .Err   (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit sel, input bit req,
                       input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [3:0] be);
    if (sel) begin
      b_req = req; b_we = we; b_addr = addr;
      b_wdata = wdata; b_be = be;
    end else begin
      a_req = req; a_we = we; a_addr = addr;
      a_wdata = wdata; a_be = be;
    end
  endtask

  // One transaction; lat = edges after capture edge
  // until Ack is seen (-1 on timeout). Fields are
  // scrambled after capture to prove they are latched.
  task automatic txn(input bit sel, input bit we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] be,
                     output logic [31:0] rdata,
                     output logic err,
                     output int lat,
                     output logic ack_next);
    lat = -1;
    rdata = 'x;
    err = 1'bx;
    @(negedge clk);
    drive(sel, 1'b1, we, addr, wdata, be);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 0)
        drive(sel, 1'b1, ~we, addr ^ 32'h4, ~wdata, ~be);
      if (sel ? b_ack : a_ack) begin
        lat = i;
        rdata = sel ? b_rdata : a_rdata;
        err = sel ? b_err : a_err;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    ack_next = sel ? b_ack : a_ack;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    #23;
    checks++;
    if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {a_ack, a_err, b_ack, b_err});
    end
    checks++;
    if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h/%h want 0",
               a_rdata, b_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_ack, a_err} !== 2'b0 || a_rdata !== 32'h0) begin
      errors++;
      $display("FAIL post_reset got ack=%b err=%b rd=%h",
               a_ack, a_err, a_rdata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF,
        rd, er, lat, an);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL wr_latency got %0d want 3", lat);
    end
    checks++;
    if (er !== 1'b0 || an !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_pulse got err=%b ack+1=%b want 0 0",
               er, an);
    end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL rd_10 got %h err=%b want deadbeef 0",
               rd, er);
    end
    checks++;
    if (lat !== 3 || an !== 1'b0) begin
      errors++;
      $display("FAIL rd_timing got lat=%0d ack+1=%b want 3 0",
               lat, an);
    end
    txn(1'b0, 1'b1, 32'h14, 32'h01020304, 4'hF,
        rd, er, lat, an);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 3) begin
      errors++;
      $display("FAIL wr_keeps_rdata got %h lat=%0d want deadbeef 3",
               rd, lat);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF,
        rd, er, lat, an);
    txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101,
        rd, er, lat, an);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      errors++;
      $display("FAIL be_0101 got %h err=%b want 11bb33dd 0",
               rd, er);
    end
    txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000,
        rd, er, lat, an);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL be_none_resp got lat=%0d err=%b want 3 0",
               lat, er);
    end
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_none_mem got %h want 11bb33dd", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    txn(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF,
        rd, er, lat, an);
    txn(1'b0, 1'b1, 32'h400, 32'h12345678, 4'hF,
        rd, er, lat, an);
    checks++;
    if (er !== 1'b1 || lat !== 3) begin
      errors++;
      $display("FAIL oor_wr got err=%b lat=%0d want 1 3",
               er, lat);
    end
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++;
      $display("FAIL oor_word0 got %h err=%b want cafef00d 0",
               rd, er);
    end
    txn(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL oor_rd got %h err=%b want 0 1", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    int          n_ack;
    int          t0, t1;
    logic [31:0] d0, d1;
    txn(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF,
        rd, er, lat, an);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL w0_latency got %0d want 1", lat);
    end
    txn(1'b1, 1'b1, 32'h4, 32'h5A5A5A5A, 4'hF,
        rd, er, lat, an);
    n_ack = 0; t0 = -1; t1 = -1;
    d0 = 'x; d1 = 'x;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (b_ack) begin
        n_ack++;
        if (n_ack == 1) begin
          t0 = i; d0 = b_rdata;
          drive(1'b1, 1'b1, 1'b0, 32'h4, '0, '0);
        end else begin
          t1 = i; d1 = b_rdata;
          drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        end
      end
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (n_ack !== 2 || t1 - t0 !== 2) begin
      errors++;
      $display("FAIL b2b_spacing got n=%0d gap=%0d want 2 2",
               n_ack, t1 - t0);
    end
    checks++;
    if (d0 !== 32'hA5A5A5A5 || d1 !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL b2b_data got %h %h want a5a5a5a5 5a5a5a5a",
               d0, d1);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    int          n_ack;
    txn(1'b0, 1'b1, 32'h8, 32'h55555555, 4'hF,
        rd, er, lat, an);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    n_ack = a_ack ? 1 : 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (a_ack) n_ack++;
    end
    checks++;
    if (n_ack !== 0) begin
      errors++;
      $display("FAIL rst_abort_ack got %0d acks want 0", n_ack);
    end
    txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, an);
    checks++;
    if (rd !== 32'h55555555 || er !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort_mem got %h err=%b want 55555555 0",
               rd, er);
    end
  endtask

  task automatic test_align();
    logic [31:0] rd;
    logic        er, an;
    int          lat;
    txn(1'b0, 1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat, an);
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned got %h err=%b want 0 1", rd, er);
    end
`else
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL unaligned got %h err=%b want deadbeef 0",
               rd, er);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_wait();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
